gray_adaptive_binarize: RTL and testbench

- Downstream consumer of the gray median filter output stream.
- Converts 8-bit filtered gray pixels to a binary image (0/255) using a per-frame adaptive threshold.
- The threshold is the mean gray level of the previous frame plus a signed offset, clamped to 0..255. It is computed by a sequential divider during vertical blanking.
- Feeds later morphology/edge stages with the same vsync/valid/clken stream format.

---
 rtl/gray_vip_pkg.sv | 20 ++
 rtl/seq_udiv.sv | 87 ++++++++
 rtl/gray_adaptive_binarize.sv | 152 +++++++++++++++
 tb/tb_gray_adaptive_binarize.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_vip_pkg.sv
// rtl/gray_vip_pkg.sv - shared constants, divider states and width helper for the gray video pipeline
package gray_vip_pkg;

    localparam int GRAY_W = 8;

    localparam logic [GRAY_W-1:0] BIN_HI = 8'hFF;
    localparam logic [GRAY_W-1:0] BIN_LO = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int width_for(input longint unsigned max_val);
        return $clog2(max_val + 64'd1);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// rtl/seq_udiv.sv - restoring unsigned divider, one quotient bit per cycle
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           load operands and begin (ignored unless idle)
//   i_dividend        WIDTH_N-bit numerator
//   i_divisor         WIDTH_D-bit denominator (caller guarantees non-zero)
//   o_busy            high from the cycle after start until back in idle
//   o_done            one-cycle pulse, o_quotient valid
//   o_quotient        WIDTH_N-bit result
module seq_udiv
    import gray_vip_pkg::*;
#(
    parameter int WIDTH_N = 27,
    parameter int WIDTH_D = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH_N-1:0] i_dividend,
    input  logic [WIDTH_D-1:0] i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH_N-1:0] o_quotient
);

    localparam int IDX_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

    div_state_t         r_state;
    logic [WIDTH_N-1:0] r_num;   // dividend, shifted left as its bits are consumed
    logic [WIDTH_N-1:0] r_quot;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_D-1:0] r_den;
    logic [IDX_W-1:0]   r_idx;

    logic [WIDTH_D:0]   w_trial;
    logic [WIDTH_D-1:0] w_diff;
    logic               w_fits;

    // Partial remainder with the next dividend bit appended; the extra top bit
    // keeps the compare exact when the shifted remainder exceeds WIDTH_D bits.
    assign w_trial = {r_rem, r_num[WIDTH_N-1]};
    assign w_fits  = (w_trial >= {1'b0, r_den});
    // Only used when w_fits, where the true difference is below r_den.
    assign w_diff  = w_trial[WIDTH_D-1:0] - r_den;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_den   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num   <= i_dividend;
                        r_den   <= i_divisor;
                        r_rem   <= '0;
                        r_quot  <= '0;
                        r_idx   <= IDX_W'(WIDTH_N - 1);
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_fits ? w_diff : w_trial[WIDTH_D-1:0];
                    r_quot <= {r_quot[WIDTH_N-2:0], w_fits};
                    r_num  <= {r_num[WIDTH_N-2:0], 1'b0};
                    if (r_idx == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_quotient = r_quot;

endmodule

// File: rtl/gray_adaptive_binarize.sv
// rtl/gray_adaptive_binarize.sv - per-frame adaptive-threshold binarizer for filtered gray video
//
// Ports:
//   clk, rst                         pixel clock, asynchronous active-high reset
//   pre_gray_vsync/valid/clken/data  input stream (vsync high for the whole frame)
//   ext_thresh, thresh_mode          manual threshold and its select (1 = manual)
//   post_bin_vsync/valid/clken/data  output stream, one cycle behind, data 0x00/0xFF
//   cur_thresh                       threshold applied to the current frame
module gray_adaptive_binarize
    import gray_vip_pkg::*;
#(
    parameter int                IMG_HDISP     = 640,
    parameter int                IMG_VDISP     = 480,
    parameter logic [7:0]        INIT_THRESH   = 8'd128,
    parameter logic signed [8:0] THRESH_OFFSET = 9'sd0,
    parameter bit                INVERT        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pre_gray_vsync,
    input  logic              pre_gray_valid,
    input  logic              pre_gray_clken,
    input  logic [GRAY_W-1:0] pre_gray_data,
    input  logic [GRAY_W-1:0] ext_thresh,
    input  logic              thresh_mode,
    output logic              post_bin_vsync,
    output logic              post_bin_valid,
    output logic              post_bin_clken,
    output logic [GRAY_W-1:0] post_bin_data,
    output logic [GRAY_W-1:0] cur_thresh
);

    localparam longint unsigned PIX_MAX = 64'(IMG_HDISP) * 64'(IMG_VDISP);
    localparam int SUM_W = width_for(PIX_MAX * 64'd255);
    localparam int CNT_W = width_for(PIX_MAX);

    logic              r_vsync, r_valid, r_clken, r_vsync_d;
    logic [GRAY_W-1:0] r_bin;
    logic [GRAY_W-1:0] r_thresh;
    logic [GRAY_W-1:0] r_pend;
    logic              r_pend_vld;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_vs_rise, w_vs_fall, w_acc;
    logic [SUM_W-1:0]  w_sum_base, w_sum_next;
    logic [CNT_W-1:0]  w_cnt_base, w_cnt_next;
    logic [SUM_W:0]    w_sum_add;
    logic [CNT_W:0]    w_cnt_add;
    logic              w_div_start, w_div_busy, w_div_done;
    logic [SUM_W-1:0]  w_quot;
    logic [GRAY_W-1:0] w_mean;
    logic signed [10:0] w_t;
    logic [GRAY_W-1:0] w_t_clamped;

    assign w_vs_rise = r_vsync & ~r_vsync_d;
    assign w_vs_fall = ~r_vsync & r_vsync_d;
    assign w_acc     = pre_gray_vsync & pre_gray_valid & pre_gray_clken;

    // A pixel landing on the rise cycle starts the new sum instead of being cleared.
    assign w_sum_base = w_vs_rise ? '0 : r_sum;
    assign w_cnt_base = w_vs_rise ? '0 : r_cnt;
    assign w_sum_add  = {1'b0, w_sum_base} + {{(SUM_W + 1 - GRAY_W){1'b0}}, pre_gray_data};
    assign w_cnt_add  = {1'b0, w_cnt_base} + (CNT_W + 1)'(1);
    assign w_sum_next = w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];
    assign w_cnt_next = w_cnt_add[CNT_W] ? '1 : w_cnt_add[CNT_W-1:0];

    // A fall during a running divide (very short frame) is dropped.
    assign w_div_start = w_vs_fall & ~w_div_busy & (r_cnt != '0);

    seq_udiv #(
        .WIDTH_N (SUM_W),
        .WIDTH_D (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (r_sum),
        .i_divisor  (r_cnt),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    // The mean cannot exceed 255; saturate anyway so a saturated sum stays sane.
    assign w_mean = (|w_quot[SUM_W-1:GRAY_W]) ? BIN_HI : w_quot[GRAY_W-1:0];
    assign w_t    = $signed({3'b000, w_mean}) + $signed({{2{THRESH_OFFSET[8]}}, THRESH_OFFSET});

    always_comb begin
        w_t_clamped = w_t[GRAY_W-1:0];
        if (w_t < 11'sd0) begin
            w_t_clamped = 8'd0;
        end else if (w_t > 11'sd255) begin
            w_t_clamped = 8'd255;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync    <= 1'b0;
            r_valid    <= 1'b0;
            r_clken    <= 1'b0;
            r_vsync_d  <= 1'b0;
            r_bin      <= BIN_LO;
            r_thresh   <= INIT_THRESH;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_sum      <= '0;
            r_cnt      <= '0;
        end else begin
            r_vsync   <= pre_gray_vsync;
            r_valid   <= pre_gray_valid;
            r_clken   <= pre_gray_clken;
            r_vsync_d <= r_vsync;

            if (!pre_gray_valid) begin
                r_bin <= BIN_LO;
            end else if (pre_gray_clken) begin
                r_bin <= ((pre_gray_data > r_thresh) ^ INVERT) ? BIN_HI : BIN_LO;
            end

            if (w_vs_rise || w_acc) begin
                r_sum <= w_acc ? w_sum_next : '0;
                r_cnt <= w_acc ? w_cnt_next : '0;
            end

            // Threshold only moves on a frame start, so it is constant within a frame.
            if (w_vs_rise) begin
                if (thresh_mode) begin
                    r_thresh <= ext_thresh;
                end else if (r_pend_vld) begin
                    r_thresh <= r_pend;
                end
            end

            // A completion on the rise cycle still lands: the rise consumed the old value.
            if (w_div_done) begin
                r_pend     <= w_t_clamped;
                r_pend_vld <= 1'b1;
            end else if (w_vs_rise && !thresh_mode && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign post_bin_vsync = r_vsync;
    assign post_bin_valid = r_valid;
    assign post_bin_clken = r_clken;
    assign post_bin_data  = r_bin;
    assign cur_thresh     = r_thresh;

endmodule

// File: tb/tb_gray_adaptive_binarize.sv
// tb/tb_gray_adaptive_binarize.sv - scoreboard bench for gray_adaptive_binarize over four parameter sets
module tb_gray_adaptive_binarize;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vs = 1'b0, va = 1'b0, ck = 1'b0, mode = 1'b0;
    logic [7:0] din = 8'd0, ext = 8'd0;

    logic       o_vs [4];
    logic       o_va [4];
    logic       o_ck [4];
    logic [7:0] o_d  [4];
    logic [7:0] o_th [4];

    always #5 clk = ~clk;

    // Instance 0 default, 1 offset -60, 2 offset +250, 3 inverted.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        gray_adaptive_binarize #(
            .THRESH_OFFSET (g == 1 ? -9'sd60 : (g == 2 ? 9'sd250 : 9'sd0)),
            .INVERT        (g == 3)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .pre_gray_vsync (vs),
            .pre_gray_valid (va),
            .pre_gray_clken (ck),
            .pre_gray_data  (din),
            .ext_thresh     (ext),
            .thresh_mode    (mode),
            .post_bin_vsync (o_vs[g]),
            .post_bin_valid (o_va[g]),
            .post_bin_clken (o_ck[g]),
            .post_bin_data  (o_d[g]),
            .cur_thresh     (o_th[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    localparam int OFF [4] = '{0, -60, 250, 0};
    localparam bit INV [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reference model: frame statistics and the threshold each instance should use.
    int      thr [4];
    int      pend_mean, infl_mean;
    bit      pend_v, infl_v, prev_long;
    longint  msum;
    int      mcnt;

    logic [2:0]  ctrl_q [$];
    logic [31:0] pix_q  [$];
    logic [2:0]  mon_e;
    logic [31:0] mon_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) thr[i] = 128;
        pend_v = 1'b0; infl_v = 1'b0; prev_long = 1'b0;
        msum = 0; mcnt = 0;
    endtask

    // Frame start: a mean finished during a long blank is ready; one still being
    // divided (short blank) is missed by this frame and becomes ready during it.
    task automatic model_rise();
        if (infl_v && prev_long) begin
            pend_mean = infl_mean; pend_v = 1'b1; infl_v = 1'b0;
        end
        if (mode) begin
            for (int i = 0; i < 4; i++) thr[i] = ext;
        end else if (pend_v) begin
            for (int i = 0; i < 4; i++) thr[i] = clamp(pend_mean + OFF[i]);
            pend_v = 1'b0;
        end
        if (infl_v) begin
            pend_mean = infl_mean; pend_v = 1'b1; infl_v = 1'b0;
        end
        msum = 0; mcnt = 0;
    endtask

    task automatic step(input bit s_vs, input bit s_va, input bit s_ck, input logic [7:0] s_d);
        logic [31:0] ex;
        @(negedge clk);
        vs = s_vs; va = s_va; ck = s_ck; din = s_d;
        ctrl_q.push_back({s_vs, s_va, s_ck});
        if (s_va && s_ck) begin
            if (s_vs) begin
                msum += s_d; mcnt++;
            end
            for (int i = 0; i < 4; i++)
                ex[8*i +: 8] = ((int'(s_d) > thr[i]) ^ INV[i]) ? 8'hFF : 8'h00;
            pix_q.push_back(ex);
        end
    endtask

    task automatic run_frame(input int vals [$], input int blank, input bit toggle);
        model_rise();
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 4; i++) check("thresh_at_start", o_th[i], thr[i]);
        for (int k = 0; k < vals.size(); k++) begin
            if ($urandom_range(0, 3) == 0) step(1'b1, 1'b1, 1'b0, 8'($urandom));
            step(1'b1, 1'b1, 1'b1, 8'(vals[k]));
            if (k % 4 == 3) begin
                step(1'b1, 1'b0, 1'($urandom), 8'($urandom));
                step(1'b1, 1'b0, 1'b0, 8'($urandom));
            end
        end
        repeat (15) step(1'b1, 1'b0, 1'b0, 8'd0);
        if (toggle) mode = ~mode;
        repeat (15) step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) check("thresh_in_frame", o_th[i], thr[i]);
        if (mcnt > 0) begin
            infl_mean = int'(msum / mcnt); infl_v = 1'b1;
        end
        repeat (blank) step(1'b0, 1'b0, 1'b0, 8'd0);
        prev_long = (blank >= 40);
    endtask

    function automatic void fill_rand(output int q [$], input int n);
        q = {};
        for (int k = 0; k < n; k++) q.push_back(int'($urandom_range(0, 255)));
    endfunction

    // Monitor: consumes one control expectation per cycle and one pixel
    // expectation whenever the DUT presents a valid, enabled pixel.
    always @(posedge clk) begin
        #2;
        if (!rst && ctrl_q.size() > 0) begin
            mon_e = ctrl_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                check("ctrl_delay", {o_vs[i], o_va[i], o_ck[i]}, mon_e);
                if (!mon_e[1]) check("data_zero_when_invalid", o_d[i], 0);
            end
        end
        if (!rst && o_va[0] && o_ck[0]) begin
            if (pix_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pixel_unexpected: got a pixel expected none at %0t", $time);
            end else begin
                mon_p = pix_q.pop_front();
                for (int i = 0; i < 4; i++) check("pixel", o_d[i], mon_p[8*i +: 8]);
            end
        end
    end

    initial begin
        int vals [$];
        model_reset();
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            check("reset_out", {o_vs[i], o_va[i], o_ck[i]}, 0);
            check("reset_data", o_d[i], 0);
            check("reset_thresh", o_th[i], 128);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        vals = '{200, 200, 200, 200, 200, 200, 200, 200};
        run_frame(vals, 60, 1'b0);
        vals = '{10, 20, 30, 40, 50, 60, 70, 80};
        run_frame(vals, 60, 1'b0);
        run_frame(vals, 60, 1'b0);

        // Short blanks: the divide is still running at the next frame start.
        vals = '{200, 200, 200, 200, 200, 200, 200, 200};
        run_frame(vals, 5, 1'b0);
        fill_rand(vals, 8);  run_frame(vals, 5, 1'b0);
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b0);
        fill_rand(vals, 4);  run_frame(vals, 60, 1'b0);

        // Manual threshold selected mid-frame, effective at the next frame.
        ext = 8'd100;
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b1);
        vals = '{100, 101, 99, 102, 0, 255, 100, 101};
        run_frame(vals, 60, 1'b1);
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b0);

        for (int f = 0; f < 8; f++) begin
            ext  = 8'($urandom);
            mode = 1'($urandom);
            fill_rand(vals, 4 * $urandom_range(1, 3));
            run_frame(vals, ($urandom_range(0, 1) != 0) ? 60 : 5, 1'b0);
        end

        // Reset while the divider is busy in the blank after a frame.
        mode = 1'b0;
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b0);
        fill_rand(vals, 8);  run_frame(vals, 8, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("midreset_out", {o_vs[i], o_va[i], o_ck[i]}, 0);
            check("midreset_data", o_d[i], 0);
            check("midreset_thresh", o_th[i], 128);
        end
        ctrl_q.delete();
        pix_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b0);
        fill_rand(vals, 8);  run_frame(vals, 60, 1'b0);

        repeat (4) @(negedge clk);
        check("pixel_queue_drained", pix_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
